// File: rtl/mul_wb_queue_if.sv
// ============================================================================
// Module      : mul_wb_queue_if
// Description : Bus bundle between the multiplier writeback queue and its
//               surroundings: scheduler credits, multiplier result capture,
//               and the shared completion / HI-LO PRF write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

interface mul_wb_queue_if;
    // scheduler side
    logic                              issue_go;
    logic                              mul_can_issue;
    // multiplier result side
    logic                              mul_complete;
    logic [63:0]                       mul_y;
    logic [`LG_ROB_ENTRIES-1:0]        mul_rob_ptr;
    logic                              mul_hilo_val;
    logic [`LG_HILO_PRF_ENTRIES-1:0]   mul_hilo_ptr;
    // completion / HI-LO write side
    logic                              cmpl_valid;
    logic                              cmpl_ready;
    logic [`LG_ROB_ENTRIES-1:0]        cmpl_rob_ptr;
    logic                              hilo_wr_en;
    logic [`LG_HILO_PRF_ENTRIES-1:0]   hilo_wr_ptr;
    logic [63:0]                       hilo_wr_data;
    logic                              ovf_err;

    // environment: scheduler, multiplier and completion arbiter
    modport master (
        output issue_go, mul_complete, mul_y, mul_rob_ptr, mul_hilo_val,
               mul_hilo_ptr, cmpl_ready,
        input  mul_can_issue, cmpl_valid, cmpl_rob_ptr, hilo_wr_en,
               hilo_wr_ptr, hilo_wr_data, ovf_err
    );

    // the writeback queue itself
    modport slave (
        input  issue_go, mul_complete, mul_y, mul_rob_ptr, mul_hilo_val,
               mul_hilo_ptr, cmpl_ready,
        output mul_can_issue, cmpl_valid, cmpl_rob_ptr, hilo_wr_en,
               hilo_wr_ptr, hilo_wr_data, ovf_err
    );
endinterface

`default_nettype wire

// File: rtl/mul_wb_queue.sv
// ============================================================================
// Module      : mul_wb_queue
// Description : Writeback-side receiver for the pipelined multiplier. Buffers
//               results in a DEPTH-entry FIFO, drains them onto the completion
//               / HI-LO write port under valid/ready, and owns the issue
//               credits that keep the backpressure-free multiplier from
//               overrunning the FIFO.
//               Optional feature macro: MUL_WB_BYPASS_EN (same-cycle result
//               forwarding when the FIFO is empty).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module mul_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    mul_wb_queue_if.slave bus
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cr_w  = $clog2(DEPTH + 1);
    localparam logic [c_cr_w-1:0] c_full_credits = c_cr_w'(DEPTH);

    // entry storage
    logic [63:0]                     r_y    [DEPTH];
    logic [`LG_ROB_ENTRIES-1:0]      r_rob  [DEPTH];
    logic                            r_hval [DEPTH];
    logic [`LG_HILO_PRF_ENTRIES-1:0] r_hptr [DEPTH];

    // pointers carry one extra wrap bit to tell full from empty
    logic [c_idx_w:0]  r_head;
    logic [c_idx_w:0]  r_tail;
    logic [c_cr_w-1:0] r_credits;
    logic              r_ovf;

    logic [c_idx_w-1:0] w_head_idx;
    logic [c_idx_w-1:0] w_tail_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_byp;
    logic               w_accept;
    logic               w_fifo_deq;
    logic               w_enq_req;
    logic               w_enq;
    logic               w_drop;
    logic               w_take;
    logic               w_hval_sel;
    logic [c_cr_w-1:0]  w_credits_nxt;

    assign w_head_idx = r_head[c_idx_w-1:0];
    assign w_tail_idx = r_tail[c_idx_w-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[c_idx_w] != r_tail[c_idx_w]) &&
                        (w_head_idx == w_tail_idx);

`ifdef MUL_WB_BYPASS_EN
    // an arriving result may be presented directly when nothing is queued
    assign w_byp = w_empty & bus.mul_complete;
`else
    assign w_byp = 1'b0;
`endif

    // head presentation: forwarded result takes priority only when empty
    always_comb begin
        bus.cmpl_valid   = !w_empty;
        bus.cmpl_rob_ptr = r_rob[w_head_idx];
        bus.hilo_wr_ptr  = r_hptr[w_head_idx];
        bus.hilo_wr_data = r_y[w_head_idx];
        w_hval_sel       = r_hval[w_head_idx];
        if (w_byp) begin
            bus.cmpl_valid   = 1'b1;
            bus.cmpl_rob_ptr = bus.mul_rob_ptr;
            bus.hilo_wr_ptr  = bus.mul_hilo_ptr;
            bus.hilo_wr_data = bus.mul_y;
            w_hval_sel       = bus.mul_hilo_val;
        end
    end

    assign w_accept       = bus.cmpl_valid & bus.cmpl_ready;
    assign bus.hilo_wr_en = w_accept & w_hval_sel;
    assign w_fifo_deq     = w_accept & !w_empty;
    // a forwarded and accepted result never touches the FIFO
    assign w_enq_req      = bus.mul_complete & !(w_byp & bus.cmpl_ready);
    // a full FIFO can still take a result when its head leaves this cycle
    assign w_enq          = w_enq_req & (!w_full | w_fifo_deq);
    assign w_drop         = w_enq_req & w_full & !w_fifo_deq;

    assign w_take            = bus.issue_go & (r_credits != '0);
    assign bus.mul_can_issue = (r_credits != '0);
    assign bus.ovf_err       = r_ovf;

    // credit arithmetic: issue takes one, any accepted completion returns one
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_take && !w_accept) begin
            w_credits_nxt = r_credits - c_cr_w'(1);
        end else if (!w_take && w_accept && (r_credits != c_full_credits)) begin
            w_credits_nxt = r_credits + c_cr_w'(1);
        end
    end

    // pointer, credit and overflow-flag state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_credits <= c_full_credits;
            r_ovf     <= 1'b0;
        end else begin
            if (w_fifo_deq) r_head <= r_head + 1'b1;
            if (w_enq)      r_tail <= r_tail + 1'b1;
            r_credits <= w_credits_nxt;
            if (w_drop)     r_ovf <= 1'b1;
        end
    end

    // entry storage write; cleared on reset so idle data outputs read zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_y[i]    <= '0;
                r_rob[i]  <= '0;
                r_hval[i] <= 1'b0;
                r_hptr[i] <= '0;
            end
        end else if (w_enq) begin
            r_y[w_tail_idx]    <= bus.mul_y;
            r_rob[w_tail_idx]  <= bus.mul_rob_ptr;
            r_hval[w_tail_idx] <= bus.mul_hilo_val;
            r_hptr[w_tail_idx] <= bus.mul_hilo_ptr;
        end
    end

    // protocol monitors: issuing without credit, or a result lost to a full FIFO
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.issue_go && (r_credits == '0)))
                else $warning("mul_wb_queue: issue_go with no credits");
            assert (!w_drop)
                else $warning("mul_wb_queue: result dropped, queue full");
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_wb_queue.sv
// ============================================================================
// Module      : tb_mul_wb_queue
// Description : Self-checking bench for mul_wb_queue: directed scenarios
//               followed by a randomized phase, all compared against a
//               queue-based reference model of the writeback behaviour.
//               Honours MUL_WB_BYPASS_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 4
`endif

module tb_mul_wb_queue;

    localparam int DEPTH = 4;
    localparam int RW    = `LG_ROB_ENTRIES;
    localparam int HW    = `LG_HILO_PRF_ENTRIES;

    typedef struct {
        logic [63:0]   y;
        logic [RW-1:0] rob;
        logic          hv;
        logic [HW-1:0] hp;
    } ent_t;

    logic clk;
    logic reset;
    mul_wb_queue_if bus ();

    mul_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    ent_t q[$];
    int   credits;
    bit   ovf;
    int   outstanding;

    int n_checks;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic model_clear();
        q.delete();
        credits     = DEPTH;
        ovf         = 1'b0;
        outstanding = 0;
    endtask

    // one clock of stimulus: drive, compare against model, advance model
    task automatic step(input bit iss, input bit cmp, input logic [63:0] y,
                        input logic [RW-1:0] rob, input bit hv,
                        input logic [HW-1:0] hp, input bit rdy);
        ent_t inc;
        ent_t h;
        bit   byp;
        bit   ev;
        bit   acc;
        @(negedge clk);
        bus.issue_go     = iss;
        bus.mul_complete = cmp;
        bus.mul_y        = y;
        bus.mul_rob_ptr  = rob;
        bus.mul_hilo_val = hv;
        bus.mul_hilo_ptr = hp;
        bus.cmpl_ready   = rdy;
        #1;
        inc = '{y: y, rob: rob, hv: hv, hp: hp};
        byp = 1'b0;
`ifdef MUL_WB_BYPASS_EN
        byp = (q.size() == 0) && cmp;
`endif
        ev = (q.size() > 0) || byp;
        h  = byp ? inc : ((q.size() > 0) ? q[0] : '{y: '0, rob: '0, hv: 1'b0, hp: '0});
        chk("cmpl_valid",    64'(bus.cmpl_valid),    64'(ev));
        chk("mul_can_issue", 64'(bus.mul_can_issue), 64'(credits > 0));
        chk("ovf_err",       64'(bus.ovf_err),       64'(ovf));
        chk("hilo_wr_en",    64'(bus.hilo_wr_en),    64'(ev && rdy && h.hv));
        if (ev) begin
            chk("cmpl_rob_ptr", 64'(bus.cmpl_rob_ptr), 64'(h.rob));
            chk("hilo_wr_ptr",  64'(bus.hilo_wr_ptr),  64'(h.hp));
            chk("hilo_wr_data", bus.hilo_wr_data,      h.y);
        end
        @(posedge clk);
        acc = ev && rdy;
        if (acc && !byp) void'(q.pop_front());
        if (cmp && !(byp && rdy)) begin
            if (q.size() < DEPTH) q.push_back(inc);
            else ovf = 1'b1;
        end
        if (iss && credits > 0) credits--;
        if (acc && credits < DEPTH) credits++;
        if (iss) outstanding++;
        if (cmp && outstanding > 0) outstanding--;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 64'd0, '0, 1'b0, '0, rdy);
    endtask

    task automatic complete(input logic [RW-1:0] rob, input bit rdy);
        step(1'b0, 1'b1, {32'hA5A5_0000 | 32'(rob), 32'(rob) * 32'h0101_0101},
             rob, 1'b1, HW'(rob), rdy);
    endtask

    // asynchronous reset in mid-cycle; outputs must clear without a clock edge
    task automatic async_reset();
        @(negedge clk);
        bus.issue_go     = 1'b0;
        bus.mul_complete = 1'b0;
        bus.cmpl_ready   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_cmpl_valid",    64'(bus.cmpl_valid),    64'd0);
        chk("rst_hilo_wr_en",    64'(bus.hilo_wr_en),    64'd0);
        chk("rst_mul_can_issue", 64'(bus.mul_can_issue), 64'd1);
        chk("rst_ovf_err",       64'(bus.ovf_err),       64'd0);
        chk("rst_hilo_wr_data",  bus.hilo_wr_data,       64'd0);
        chk("rst_cmpl_rob_ptr",  64'(bus.cmpl_rob_ptr),  64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        model_clear();
        reset            = 1'b1;
        bus.issue_go     = 1'b0;
        bus.mul_complete = 1'b0;
        bus.mul_y        = '0;
        bus.mul_rob_ptr  = '0;
        bus.mul_hilo_val = 1'b0;
        bus.mul_hilo_ptr = '0;
        bus.cmpl_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset then idle
        idle(1'b0);
        idle(1'b1);

        // single result, ready high
        step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 64'h0000_0001_FFFF_FFFE, RW'(5), 1'b1, HW'(3), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // backpressure: four issues, four completions held, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) complete(RW'(i), 1'b0);
        idle(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // full queue with simultaneous enqueue and dequeue
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) complete(RW'(10 + i), 1'b0);
        for (int i = 0; i < DEPTH; i++) complete(RW'(20 + i), 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // forced overflow: fifth result while full and not draining
        async_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) complete(RW'(30 + i), 1'b0);
        complete(RW'(9), 1'b0);
        idle(1'b0);
        idle(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // result that completes in the ROB only
        async_reset();
        step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, RW'(7), 1'b0, HW'(2), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // asynchronous reset with two entries queued
        step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 64'd0, '0, 1'b0, '0, 1'b0);
        complete(RW'(40), 1'b0);
        complete(RW'(41), 1'b0);
        idle(1'b0);
        async_reset();
        idle(1'b0);

        // randomized traffic obeying the credit protocol
        for (int c = 0; c < 400; c++) begin
            bit iss;
            bit cmp;
            iss = (credits > 0) && ($urandom_range(0, 1) == 1);
            cmp = (outstanding > 0) && ($urandom_range(0, 2) != 0);
            step(iss, cmp, {$urandom, $urandom}, RW'($urandom_range(0, (1 << RW) - 1)),
                 1'($urandom_range(0, 1)), HW'($urandom_range(0, (1 << HW) - 1)),
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
